// File: rtl/txd_task_pkg.sv
// txd_task_pkg: shared FSM state encoding and UART frame constants for the TXD worker.
package txd_task_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP, FINISH, RELEASE} state_t;
    localparam int UART_FRAME_BITS = 10;
    localparam int UART_DATA_BITS = 8;
endpackage

// File: rtl/txd_task_uart_bit_timer.sv
// uart_bit_timer: counts one UART bit period, tick marks its last clk.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    logic [W-1:0] cnt;
    assign tick = cnt == LAST;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else cnt <= (clr || tick) ? '0 : cnt + W'(1);
endmodule

// File: rtl/txd_task.sv
// txd_task: on grant, streams NUM_BYTES sample-RAM bytes out as UART 8N1, then pulses done.
module txd_task
    import txd_task_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int NUM_BYTES    = 256,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              grant,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              txd,
    output logic              busy
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BYTES - 1);
    state_t     state;
    logic [7:0] shift;
    logic [2:0] bit_idx;
    logic       tick;
    logic       clr;
    // The timer only runs inside a frame; holding it clear elsewhere restarts it on every frame entry.
    assign clr = !(state inside {START, DATA, STOP});
    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .tick(tick)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state    <= IDLE;
            txd      <= 1'b1;
            done     <= 1'b0;
            busy     <= 1'b0;
            mem_addr <= '0;
            shift    <= '0;
            bit_idx  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (grant) begin
                    busy     <= 1'b1;
                    mem_addr <= '0;
                    state    <= FETCH;
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    shift   <= mem_data;
                    bit_idx <= '0;
                    txd     <= 1'b0;
                    state   <= START;
                end
                START: if (tick) begin
                    txd   <= shift[0];
                    state <= DATA;
                end
                DATA: if (tick) begin
                    shift   <= shift >> 1;
                    bit_idx <= bit_idx + 3'd1;
                    txd     <= (bit_idx == 3'(UART_DATA_BITS - 1)) ? 1'b1 : shift[1];
                    if (bit_idx == 3'(UART_DATA_BITS - 1)) state <= STOP;
                end
                STOP: if (tick) begin
                    if (!grant) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (mem_addr == LAST_ADDR) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FINISH;
                    end else begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                        state    <= FETCH;
                    end
                end
                FINISH: begin
                    mem_addr <= '0;
                    state    <= RELEASE;
                end
                RELEASE: if (!grant) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_txd_task.sv
// tb_txd_task: directed + randomized checks of txd_task against a frame-level UART model.
module tb_txd_task;
    localparam int NB = 2;
    localparam int C  = 4;
    logic       clk = 1'b1;
    logic       rst = 1'b1;
    logic       grant = 1'b0;
    logic       done, txd, busy;
    logic [7:0] mem_addr;
    logic [7:0] mem_data = '0;
    logic [7:0] ram [256];
    int total = 0;
    int passed = 0;

    txd_task #(.ADDR_W(8), .NUM_BYTES(NB), .CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst(rst), .grant(grant), .done(done),
        .mem_addr(mem_addr), .mem_data(mem_data), .txd(txd), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) mem_data <= ram[mem_addr];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    // Checks one cycle's outputs #1 after a posedge, then advances to the next posedge.
    task automatic sample(input string tag, input logic t, input logic b, input logic d, input int a);
        #1;
        chk({tag, ".txd"}, {7'd0, txd}, {7'd0, t});
        chk({tag, ".busy"}, {7'd0, busy}, {7'd0, b});
        chk({tag, ".done"}, {7'd0, done}, {7'd0, d});
        if (a >= 0) chk({tag, ".addr"}, mem_addr, 8'(a));
        @(posedge clk);
    endtask

    // Expected line: per byte two idle-high clks then start, 8 data bits LSB first, stop, each C clks.
    task automatic transfer(input string tag, input int drop_at);
        logic [9:0] fr;
        int n = 0;
        @(negedge clk) grant = 1'b1;
        @(posedge clk);
        for (int k = 0; k < NB; k++) begin
            fr = {1'b1, ram[k], 1'b0};
            for (int j = 0; j < 2 + 10 * C; j++) begin
                sample(tag, (j < 2) ? 1'b1 : fr[(j - 2) / C], 1'b1, 1'b0, k);
                n++;
                if (n == drop_at) grant = 1'b0;
            end
            if (!grant) break;
        end
        if (!grant) begin
            for (int j = 0; j < 6; j++) sample({tag, ".abort"}, 1'b1, 1'b0, 1'b0, -1);
        end else begin
            sample({tag, ".finish"}, 1'b1, 1'b0, 1'b1, NB - 1);
            sample({tag, ".release"}, 1'b1, 1'b0, 1'b0, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(i);
        ram[0] = 8'hA5;
        ram[1] = 8'h3C;
        #5 rst = 1'b0;
        #2;
        chk("rst.txd", {7'd0, txd}, 8'd1);
        chk("rst.busy", {7'd0, busy}, 8'd0);
        chk("rst.done", {7'd0, done}, 8'd0);
        chk("rst.addr", mem_addr, 8'd0);
        #5;
        chk("rst2.txd", {7'd0, txd}, 8'd1);
        chk("rst2.addr", mem_addr, 8'd0);
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        sample("idle", 1'b1, 1'b0, 1'b0, 0);

        transfer("xfer1", -1);
        for (int j = 0; j < 10; j++) sample("held", 1'b1, 1'b0, 1'b0, 0);
        @(negedge clk) grant = 1'b0;
        @(posedge clk);
        sample("low", 1'b1, 1'b0, 1'b0, 0);
        transfer("xfer2", -1);
        @(negedge clk) grant = 1'b0;

        for (int r = 0; r < 3; r++) begin
            ram[0] = 8'($urandom);
            ram[1] = 8'($urandom);
            repeat (2) @(posedge clk);
            transfer("rand", -1);
            @(negedge clk) grant = 1'b0;
        end

        for (int r = 0; r < 2; r++) begin
            ram[0] = 8'($urandom);
            repeat (2) @(posedge clk);
            transfer("abort", $urandom_range(3 + C, 2 + 9 * C - 1));
        end

        // Reset during bit 3 of byte 1, whose bit 3 is forced low so txd must jump back high.
        ram[1] = 8'($urandom) & 8'hF7;
        repeat (2) @(posedge clk);
        @(negedge clk) grant = 1'b1;
        @(posedge clk);
        repeat (2 + 10 * C + 2 + 4 * C + 1) @(posedge clk);
        #1 chk("mid.addr_pre", mem_addr, 8'd1);
        chk("mid.txd_pre", {7'd0, txd}, 8'd0);
        #2 rst = 1'b0;
        #1;
        chk("mid.txd", {7'd0, txd}, 8'd1);
        chk("mid.busy", {7'd0, busy}, 8'd0);
        chk("mid.addr", mem_addr, 8'd0);
        chk("mid.done", {7'd0, done}, 8'd0);
        grant = 1'b0;
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        ram[0] = 8'($urandom);
        transfer("post_rst", -1);
        @(negedge clk) grant = 1'b0;
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
